// File: rtl/scratch_pad_rsp_buffer_if.sv
// Response-path bundle between the scratch pad, the response buffer and its consumers.
// The scratch pad and consumer side use the master view. The response buffer uses the slave view.
// Port p occupies slice [(PORTS-p)*WIDTH-1 -: WIDTH] of the flat data buses, so port 0 is at the MSB end.
interface scratch_pad_rsp_buffer_if #(
  parameter int PORTS = 8,
  parameter int WIDTH = 64
);
  logic [WIDTH*PORTS-1:0] sp_q;
  logic [0:PORTS-1]       sp_valid;
  logic [0:PORTS-1]       sp_stall;
  logic [WIDTH*PORTS-1:0] out_q;
  logic [0:PORTS-1]       out_valid;
  logic [0:PORTS-1]       out_ready;

  modport master (
    output sp_q, sp_valid, out_ready,
    input  sp_stall, out_q, out_valid
  );

  modport slave (
    input  sp_q, sp_valid, out_ready,
    output sp_stall, out_q, out_valid
  );
endinterface

// File: rtl/scratch_pad_rsp_buffer.sv
// Per-port first-word-fall-through (FWFT) response queues placed behind the multi-port scratch pad.
// Each port has its own independent queue. When a queue gets close to full, a registered stall is raised early.
// SKID slots stay free so that reads already in flight still have somewhere to land.
// Optional feature macro: SCRATCH_PAD_RSP_OVF_EN adds a sticky per-port overflow output.
module scratch_pad_rsp_buffer #(
  parameter int PORTS      = 8,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int SKID       = 2,
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  scratch_pad_rsp_buffer_if.slave bus
`ifdef SCRATCH_PAD_RSP_OVF_EN
  ,
  output logic [0:PORTS-1]       overflow
`endif
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] STALL_CNT = CNT_WIDTH'(FIFO_DEPTH - SKID);

  logic [WIDTH-1:0] head_q     [PORTS];
  logic             head_valid [PORTS];
  logic             stall_bit  [PORTS];
`ifdef SCRATCH_PAD_RSP_OVF_EN
  logic             ovf_bit    [PORTS];
`endif

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    logic [WIDTH-1:0]     mem_reg [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 stall_reg;
    logic                 push;
    logic                 pop;

    // A push is accepted only against the current count.
    // A pop in the same cycle does not make room for a push into a full queue.
    assign push = !rst && bus.sp_valid[gi] && (count_reg < FULL_CNT);
    assign pop  = (count_reg != '0) && bus.out_ready[gi];

    // Occupancy after this cycle's push and pop.
    always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
        count_next = count_reg + CNT_WIDTH'(1);
      end else if (!push && pop) begin
        count_next = count_reg - CNT_WIDTH'(1);
      end
    end

    // Storage write port. The array is not reset, because the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= bus.sp_q[(PORTS-gi)*WIDTH-1 -: WIDTH];
      end
    end

    // Pointers, occupancy and the registered early stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        stall_reg  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
        end
        count_reg <= count_next;
        stall_reg <= (count_next >= STALL_CNT);
      end
    end

    assign head_q[gi]     = mem_reg[rd_ptr_reg];
    assign head_valid[gi] = (count_reg != '0);
    assign stall_bit[gi]  = stall_reg;

`ifdef SCRATCH_PAD_RSP_OVF_EN
    logic ovf_reg;

    // The overflow flag is sticky. It is set on any valid beat that arrives while the queue is full.
    always_ff @(posedge clk) begin
      if (rst) begin
        ovf_reg <= 1'b0;
      end else if (bus.sp_valid[gi] && (count_reg == FULL_CNT)) begin
        ovf_reg <= 1'b1;
`ifndef SYNTHESIS
        $display("scratch_pad_rsp_buffer: port %0d dropped response at %0t", gi, $time);
`endif
      end
    end

    assign ovf_bit[gi] = ovf_reg;
`endif
  end

  // Pack the per-port results onto the flat interface buses.
  always_comb begin
    bus.out_q     = '0;
    bus.out_valid = '0;
    bus.sp_stall  = '0;
    for (int p = 0; p < PORTS; p++) begin
      bus.out_q[(PORTS-p)*WIDTH-1 -: WIDTH] = head_q[p];
      bus.out_valid[p]                      = head_valid[p];
      bus.sp_stall[p]                       = stall_bit[p];
    end
  end

`ifdef SCRATCH_PAD_RSP_OVF_EN
  // Collect the sticky overflow flags onto the overflow port.
  always_comb begin
    overflow = '0;
    for (int p = 0; p < PORTS; p++) begin
      overflow[p] = ovf_bit[p];
    end
  end
`endif

endmodule

// File: tb/tb_scratch_pad_rsp_buffer.sv
// Testbench for scratch_pad_rsp_buffer.
// A reference model keeps one behavioural queue per port. The bench runs directed scenarios first, then a randomized phase.
module tb_scratch_pad_rsp_buffer;
  localparam int PORTS = 8;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int SKID  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scratch_pad_rsp_buffer_if #(.PORTS(PORTS), .WIDTH(WIDTH)) bus ();
`ifdef SCRATCH_PAD_RSP_OVF_EN
  logic [0:PORTS-1] overflow;
`endif

  scratch_pad_rsp_buffer #(
    .PORTS(PORTS), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .SKID(SKID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SCRATCH_PAD_RSP_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  // Behavioural reference state
  logic [WIDTH-1:0] model_q [PORTS][$];
  bit               model_stall [PORTS];
  bit               model_ovf   [PORTS];

  // Stimulus held by the bench
  logic [WIDTH-1:0] din [PORTS];
  bit               vin [PORTS];
  bit               rin [PORTS];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < PORTS; p++) begin
      bus.sp_q[(PORTS-p)*WIDTH-1 -: WIDTH] = din[p];
      bus.sp_valid[p]  = vin[p];
      bus.out_ready[p] = rin[p];
    end
  endtask

  task automatic idle();
    for (int p = 0; p < PORTS; p++) begin
      vin[p] = 1'b0;
      rin[p] = 1'b0;
      din[p] = {$urandom, $urandom};
    end
  endtask

  // Advance one clock, apply the queue rules to the model, then compare every port.
  task automatic tick(input string phase);
    int sz;
    bit full;
    bit do_pop;
    drive();
    @(posedge clk);
    for (int p = 0; p < PORTS; p++) begin
      if (rst) begin
        model_q[p].delete();
        model_stall[p] = 1'b0;
        model_ovf[p]   = 1'b0;
      end else begin
        sz     = model_q[p].size();
        full   = (sz == DEPTH);
        do_pop = (sz != 0) && rin[p];
        if (vin[p] && full) model_ovf[p] = 1'b1;
        if (do_pop) void'(model_q[p].pop_front());
        if (vin[p] && !full) model_q[p].push_back(din[p]);
        model_stall[p] = (model_q[p].size() >= DEPTH - SKID);
      end
    end
    #1;
    for (int p = 0; p < PORTS; p++) begin
      sz = model_q[p].size();
      check($sformatf("%s out_valid[%0d] sz=%0d", phase, p, sz), WIDTH'(bus.out_valid[p]), WIDTH'(sz != 0));
      if (sz != 0)
        check($sformatf("%s out_q[%0d]", phase, p), bus.out_q[(PORTS-p)*WIDTH-1 -: WIDTH], model_q[p][0]);
      check($sformatf("%s sp_stall[%0d] sz=%0d", phase, p, sz), WIDTH'(bus.sp_stall[p]), WIDTH'(model_stall[p]));
`ifdef SCRATCH_PAD_RSP_OVF_EN
      check($sformatf("%s overflow[%0d]", phase, p), WIDTH'(overflow[p]), WIDTH'(model_ovf[p]));
`endif
    end
  endtask

  initial begin
    for (int p = 0; p < PORTS; p++) begin
      model_stall[p] = 1'b0;
      model_ovf[p]   = 1'b0;
    end
    idle();

    // 1: reset held three cycles with every valid high
    rst = 1'b1;
    for (int p = 0; p < PORTS; p++) vin[p] = 1'b1;
    repeat (3) tick("reset");
    rst = 1'b0;
    idle();
    tick("post_reset");
    check("post_reset out_valid", WIDTH'(bus.out_valid), '0);
    check("post_reset sp_stall", WIDTH'(bus.sp_stall), '0);

    // 2: one-cycle latency on port 3 with consumer ready
    for (int p = 0; p < PORTS; p++) rin[p] = 1'b1;
    vin[3] = 1'b1;
    din[3] = 64'hDEAD_BEEF;
    tick("latency_push");
    check("latency out_valid[3]", WIDTH'(bus.out_valid[3]), WIDTH'(1));
    check("latency out_q[3]", bus.out_q[(PORTS-3)*WIDTH-1 -: WIDTH], 64'hDEAD_BEEF);
    check("latency other valid", WIDTH'(bus.out_valid & 8'b1110_1111), '0);
    vin[3] = 1'b0;
    tick("latency_gone");
    check("latency out_valid[3] gone", WIDTH'(bus.out_valid[3]), '0);

    // 3: fill port 0 to eight entries, then drain it in order
    idle();
    for (int i = 1; i <= 8; i++) begin
      vin[0] = 1'b1;
      din[0] = WIDTH'(i);
      tick($sformatf("fill%0d", i));
      if (i == 5) check("fill stall after 5", WIDTH'(bus.sp_stall[0]), '0);
      if (i == 6) check("fill stall after 6", WIDTH'(bus.sp_stall[0]), WIDTH'(1));
    end
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain head %0d", i), bus.out_q[PORTS*WIDTH-1 -: WIDTH], WIDTH'(i));
      tick($sformatf("drain%0d", i));
    end

    // 4: steady push and pop on port 5 across pointer wrap
    idle();
    rin[5] = 1'b1;
    for (int i = 0; i < 21; i++) begin
      vin[5] = 1'b1;
      din[5] = 64'h5500 + WIDTH'(i);
      tick($sformatf("wrap%0d", i));
      check($sformatf("wrap stall %0d", i), WIDTH'(bus.sp_stall[5]), '0);
    end
    vin[5] = 1'b0;
    tick("wrap_end");

    // 5: overflow on port 7
    idle();
    for (int i = 0; i < 8; i++) begin
      vin[7] = 1'b1;
      din[7] = 64'h7700 + WIDTH'(i);
      tick($sformatf("ovf_fill%0d", i));
    end
    din[7] = 64'hBAD0_BAD0;
    tick("ovf_drop");
    vin[7] = 1'b0;
    tick("ovf_hold");
`ifdef SCRATCH_PAD_RSP_OVF_EN
    check("ovf flag port7", WIDTH'(overflow[7]), WIDTH'(1));
`endif
    rin[7] = 1'b1;
    repeat (9) tick("ovf_drain");

    // 6: reset while every port holds four entries
    idle();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < PORTS; p++) begin
        vin[p] = 1'b1;
        din[p] = {$urandom, $urandom};
      end
      tick("midop_fill");
    end
    rst = 1'b1;
    tick("midop_rst");
    rst = 1'b0;
    idle();
    check("midop out_valid", WIDTH'(bus.out_valid), '0);
    vin[2] = 1'b1;
    din[2] = 64'h1234_5678_9ABC_DEF0;
    tick("midop_push");
    vin[2] = 1'b0;
    rin[2] = 1'b1;
    tick("midop_pop");

    // Randomized traffic; upstream mostly honours stall, and now and then a reset is pulsed
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < PORTS; p++) begin
        vin[p] = ($urandom_range(0, 3) != 0) && (!bus.sp_stall[p] || $urandom_range(0, 7) == 0);
        rin[p] = $urandom_range(0, 1);
        din[p] = {$urandom, $urandom};
      end
      tick("random");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
